// File: rtl/i2c_target_regs.sv
// I2C target front end: oversampled SCL/SDA, START/STOP detection, address match and register write strobes.
// Define I2C_TARGET_READ_EN to add the read path (RDATA/RDATA_ACK); without it R/W=1 is NAKed.
module i2c_target_regs #(
    parameter logic [6:0] ADDR = 7'h70
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);
    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK, S_WDATA, S_WDATA_ACK, S_IGNORE
`ifdef I2C_TARGET_READ_EN
        , S_RDATA, S_RDATA_ACK
`endif
    } state_t;

    state_t     state, state_n;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d, scl, sda;
    logic       scl_rise, scl_fall, start, stop;
    logic [2:0] bit_cnt;
    logic [7:0] shift, sub_addr, byte_in;
    logic       last_bit, addr_ok, phase;
    logic       unused_bits;
`ifdef I2C_TARGET_READ_EN
    logic       rw;
`endif

    // Synchronizers reset to the idle-bus level so reset release creates no false START/STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl      = scl_sync[1];
    assign sda      = sda_sync[1];
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    assign start    = scl & scl_d & sda_d & ~sda;
    assign stop     = scl & scl_d & ~sda_d & sda;
    assign byte_in  = {shift[6:0], sda};
    assign last_bit = (bit_cnt == 3'd7);
    assign rd_addr  = sub_addr;
`ifdef I2C_TARGET_READ_EN
    assign addr_ok     = (byte_in[7:1] == ADDR);
    assign unused_bits = shift[7];
`else
    assign addr_ok     = (byte_in[7:1] == ADDR) && !byte_in[0];
    assign unused_bits = ^{shift[7], rd_data};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // phase marks the second half of an ACK slot: set by the scl_fall that starts it.
    always_comb begin
        state_n = state;
        if (stop) begin
            state_n = S_IDLE;
        end else if (start) begin
            state_n = S_ADDR;
        end else begin
            case (state)
                S_ADDR:      if (scl_rise && last_bit) state_n = addr_ok ? S_ADDR_ACK : S_IGNORE;
`ifdef I2C_TARGET_READ_EN
                S_ADDR_ACK:  if (scl_fall && phase) state_n = rw ? S_RDATA : S_SUB;
`else
                S_ADDR_ACK:  if (scl_fall && phase) state_n = S_SUB;
`endif
                S_SUB:       if (scl_rise && last_bit) state_n = S_SUB_ACK;
                S_SUB_ACK:   if (scl_fall && phase) state_n = S_WDATA;
                S_WDATA:     if (scl_rise && last_bit) state_n = S_WDATA_ACK;
                S_WDATA_ACK: if (scl_fall && phase) state_n = S_WDATA;
`ifdef I2C_TARGET_READ_EN
                S_RDATA:     if (scl_rise && last_bit) state_n = S_RDATA_ACK;
                S_RDATA_ACK: begin
                    if (phase && scl_rise && sda) state_n = S_IGNORE;
                    else if (phase && scl_fall)   state_n = S_RDATA;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_oe   <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= 8'h00;
            wr_data  <= 8'h00;
            busy     <= 1'b0;
            sub_addr <= 8'h00;
            shift    <= 8'h00;
            bit_cnt  <= 3'd0;
            phase    <= 1'b0;
`ifdef I2C_TARGET_READ_EN
            rw       <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (start || stop) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
                phase   <= 1'b0;
                if (stop) busy <= 1'b0;
            end else begin
                case (state)
                    S_ADDR, S_SUB, S_WDATA: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            if (state == S_ADDR && addr_ok) busy <= 1'b1;
`ifdef I2C_TARGET_READ_EN
                            if (state == S_ADDR) rw <= byte_in[0];
`endif
                            if (state == S_SUB) sub_addr <= byte_in;
                            if (state == S_WDATA) begin
                                wr_en    <= 1'b1;
                                wr_addr  <= sub_addr;
                                wr_data  <= byte_in;
                                sub_addr <= sub_addr + 8'd1;
                            end
                        end
                    end
                    S_ADDR_ACK, S_SUB_ACK, S_WDATA_ACK: if (scl_fall) begin
                        phase  <= ~phase;
                        sda_oe <= ~phase;
`ifdef I2C_TARGET_READ_EN
                        // The fall that ends a read-address ACK also presents the first data bit.
                        if (phase && state == S_ADDR_ACK && rw) begin
                            shift  <= rd_data;
                            sda_oe <= ~rd_data[7];
                        end
`endif
                    end
`ifdef I2C_TARGET_READ_EN
                    S_RDATA: begin
                        if (scl_fall) begin
                            shift  <= {shift[6:0], 1'b0};
                            sda_oe <= ~shift[6];
                        end
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) sub_addr <= sub_addr + 8'd1;
                        end
                    end
                    S_RDATA_ACK: begin
                        if (scl_fall) begin
                            phase <= ~phase;
                            if (phase) begin
                                shift  <= rd_data;
                                sda_oe <= ~rd_data[7];
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end else if (scl_rise && phase && sda) begin
                            phase <= 1'b0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bus controller model on an open-drain SDA line.
module tb_i2c_target_regs;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl;
    logic       sda_ctrl;
    logic       sda_line;
    logic       sda_oe;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int oe_cnt = 0;
    logic [15:0] wr_log [0:63];

    always #5 clk = ~clk;

    assign sda_line = sda_ctrl & ~sda_oe;
    assign rd_data  = 8'hA0 + rd_addr;

    i2c_target_regs dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_in  (scl),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always @(negedge clk) begin
        if (wr_en && wr_cnt < 64) begin
            wr_log[wr_cnt] <= {wr_addr, wr_data};
            wr_cnt         <= wr_cnt + 1;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not end, time %0t required < 2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic q();
        repeat (8) @(negedge clk);
    endtask

    task automatic start_cond();
        sda_ctrl = 1'b1; scl = 1'b1; q();
        sda_ctrl = 1'b0; q();
        scl = 1'b0; q();
    endtask

    task automatic rstart_cond();
        sda_ctrl = 1'b1; q();
        scl = 1'b1; q();
        sda_ctrl = 1'b0; q();
        scl = 1'b0; q();
    endtask

    task automatic stop_cond();
        sda_ctrl = 1'b0; q();
        scl = 1'b1; q();
        sda_ctrl = 1'b1; q();
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_ctrl = b[i]; q();
            scl = 1'b1; q(); q();
            scl = 1'b0; q();
        end
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_ctrl = 1'b1; q();
        scl = 1'b1; q();
        ack = sda_line; q();
        scl = 1'b0; q();
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] b);
        sda_ctrl = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            q();
            scl = 1'b1; q();
            b[i] = sda_line; q();
            scl = 1'b0;
        end
        q();
        sda_ctrl = ~give_ack; q();
        scl = 1'b1; q(); q();
        scl = 1'b0; q();
        sda_ctrl = 1'b1;
    endtask

    initial begin
        logic       a;
        logic [7:0] b;
        int         bw;
        int         bo;

        rst_n = 1'b0; scl = 1'b1; sda_ctrl = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1; q();

        // Basic write burst with auto-increment
        bw = wr_cnt;
        start_cond();
        wbyte(8'hE0, a); check("t1_ack_addr", a, 0); check("t1_busy_on", busy, 1);
        wbyte(8'h0A, a); check("t1_ack_sub", a, 0);
        wbyte(8'h55, a); check("t1_ack_d0", a, 0);
        wbyte(8'h1F, a); check("t1_ack_d1", a, 0);
        check("t1_busy_before_stop", busy, 1);
        stop_cond();
        check("t1_busy_off", busy, 0);
        check("t1_sda_oe", sda_oe, 0);
        check("t1_wr_count", 16'(wr_cnt - bw), 2);
        check("t1_wr0", wr_log[bw], 16'h0A55);
        check("t1_wr1", wr_log[bw + 1], 16'h0B1F);
        check("t1_rd_addr", rd_addr, 8'h0C);

        // Wrong device address is NAKed and ignored
        bw = wr_cnt; bo = oe_cnt;
        start_cond();
        wbyte(8'hE2, a); check("t2_nak_addr", a, 1);
        wbyte(8'h10, a); check("t2_nak_data", a, 1);
        check("t2_busy", busy, 0);
        stop_cond();
        check("t2_oe_never", 16'(oe_cnt - bo), 0);
        check("t2_no_wr", 16'(wr_cnt - bw), 0);

        // Sub-address wraps from 0xFF to 0x00
        bw = wr_cnt;
        start_cond();
        wbyte(8'hE0, a); check("t3_ack_addr", a, 0);
        wbyte(8'hFF, a); check("t3_ack_sub", a, 0);
        wbyte(8'h11, a); check("t3_ack_d0", a, 0);
        wbyte(8'h22, a); check("t3_ack_d1", a, 0);
        stop_cond();
        check("t3_wr_count", 16'(wr_cnt - bw), 2);
        check("t3_wr0", wr_log[bw], 16'hFF11);
        check("t3_wr1", wr_log[bw + 1], 16'h0022);
        check("t3_rd_addr", rd_addr, 8'h01);

        // STOP in the middle of a data byte discards it
        bw = wr_cnt;
        start_cond();
        wbyte(8'hE0, a); check("t4_ack_addr", a, 0);
        wbyte(8'h30, a); check("t4_ack_sub", a, 0);
        send_bits(8'h9C, 4);
        stop_cond();
        check("t4_no_wr", 16'(wr_cnt - bw), 0);
        check("t4_sda_oe", sda_oe, 0);
        check("t4_busy", busy, 0);
        check("t4_rd_addr", rd_addr, 8'h30);
        start_cond();
        wbyte(8'hE0, a); check("t4_re_ack_addr", a, 0);
        wbyte(8'h40, a); check("t4_re_ack_sub", a, 0);
        wbyte(8'h77, a); check("t4_re_ack_d0", a, 0);
        stop_cond();
        check("t4_re_wr_count", 16'(wr_cnt - bw), 1);
        check("t4_re_wr0", wr_log[bw], 16'h4077);
        check("t4_re_rd_addr", rd_addr, 8'h41);

`ifdef I2C_TARGET_READ_EN
        // Sub-address write, repeated START, two-byte read
        bw = wr_cnt;
        start_cond();
        wbyte(8'hE0, a); check("t5_ack_addr", a, 0);
        wbyte(8'h05, a); check("t5_ack_sub", a, 0);
        rstart_cond();
        wbyte(8'hE1, a); check("t5_ack_raddr", a, 0);
        read_byte(1'b1, b); check("t5_rd0", b, 8'hA5);
        read_byte(1'b0, b); check("t5_rd1", b, 8'hA6);
        q();
        check("t5_released", sda_oe, 0);
        check("t5_busy_on", busy, 1);
        stop_cond();
        check("t5_no_wr", 16'(wr_cnt - bw), 0);
        check("t5_rd_addr", rd_addr, 8'h07);
        check("t5_busy_off", busy, 0);
`else
        // Read request is NAKed when the read path is absent
        bo = oe_cnt;
        start_cond();
        wbyte(8'hE1, a); check("t5_nak_read", a, 1);
        check("t5_busy", busy, 0);
        stop_cond();
        check("t5_oe_never", 16'(oe_cnt - bo), 0);
        check("t5_rd_addr", rd_addr, 8'h41);
`endif

        // Reset pulse inside the address ACK slot
        start_cond();
        send_bits(8'hE0, 8);
        sda_ctrl = 1'b1; q();
        check("t6_ack_driven", sda_oe, 1);
        check("t6_busy_on", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_oe_async", sda_oe, 0);
        check("t6_wr_en", wr_en, 0);
        check("t6_wr_addr", wr_addr, 0);
        check("t6_wr_data", wr_data, 0);
        check("t6_rd_addr", rd_addr, 0);
        check("t6_busy", busy, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        q();
        scl = 1'b1; q();
        a = sda_line; check("t6_nak_seen", a, 1); q();
        scl = 1'b0; q();
        stop_cond();
        bw = wr_cnt;
        start_cond();
        wbyte(8'hE0, a); check("t6_re_ack_addr", a, 0);
        wbyte(8'h12, a); check("t6_re_ack_sub", a, 0);
        wbyte(8'h34, a); check("t6_re_ack_d0", a, 0);
        stop_cond();
        check("t6_re_wr_count", 16'(wr_cnt - bw), 1);
        check("t6_re_wr0", wr_log[bw], 16'h1234);
        check("t6_re_rd_addr", rd_addr, 8'h13);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

I2C target (slave) front end for the dice design, the responder side of the bus an external controller drives. It oversamples SCL/SDA on the system clock, detects START/STOP, and matches a 7-bit device address. A sub-address byte selects a register, and following bytes become single-cycle write strobes with auto-incrementing address for the register bank in the top level. SDA is driven open-drain through an output-enable only.

## Interface
- `ADDR`, default 7'h70: 7-bit device address matched against the first byte after START.
- `clk` in, 1: system clock; must be ≥ 16× SCL frequency.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `scl_in` in, 1: raw SCL pad input, asynchronous.
- `sda_in` in, 1: raw SDA pad input, asynchronous.
- `sda_oe` out, 1: 1 = pull SDA low; 0 = release. The pad output value is tied 0 in the top level.
- `wr_en` out, 1: one-clk write strobe.
- `wr_addr` out, 8: register address for `wr_en`.
- `wr_data` out, 8: data for `wr_en`.
- `rd_addr` out, 8: current sub-address, for the read mux.
- `rd_data` in, 8: register contents at `rd_addr`, combinational from the parent.
- `busy` out, 1: high from an addressed match until STOP.

## Operation
- Input synchronisation: SCL and SDA each pass through a 2-FF synchronizer, then a 1-FF edge register.
  - `scl_rise` / `scl_fall`: SCL edges.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Data is sampled on `scl_rise`, MSB first. A 3-bit counter tracks the bit position.
- States: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE → ADDR on START.
- ADDR → ADDR_ACK after the 8th bit when byte[7:1] == ADDR. Otherwise → IGNORE, with SDA released (NAK).
- ADDR_ACK: drive `sda_oe`=1 from the `scl_fall` after bit 8 to the next `scl_fall`. Then:
  - R/W=0 → SUB.
  - R/W=1 → RDATA.
- SUB → SUB_ACK: the received byte loads the sub-address register. ACK as above, then → WDATA.
- WDATA → WDATA_ACK on the 8th bit. Also: `wr_en`=1 for exactly one clk, `wr_addr`=sub-address, `wr_data`=byte. Sub-address increments after the strobe. ACK, then → WDATA.
- RDATA:
  - On entry, at the `scl_fall` ending the ACK slot, latch `rd_data` into the shift register.
  - Drive each bit after `scl_fall`: `sda_oe` = ~bit.
  - After 8 bits, increment the sub-address and release SDA → RDATA_ACK.
- RDATA_ACK: sample the controller's ACK on `scl_rise`.
  - SDA low → RDATA.
  - SDA high (NAK) → IGNORE.
- Any state: START → ADDR (repeated start). The sub-address is kept.
- Any state: STOP → IDLE, `sda_oe`=0. A partial byte is discarded and no strobe is issued.
- Sub-address arithmetic is 8-bit, wrapping 0xFF → 0x00.
- IGNORE: SDA released; wait for START or STOP.

## Timing
- Reset values: `sda_oe`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0, `busy`=0, state IDLE, sub-address 0.
- Reset mid-transaction releases SDA immediately (async). Resume only after a new START.
- Latency from pad edge to internal event: 3 clk.
- `wr_en` asserts 1 clk after the internal `scl_rise` of the 8th data bit.
- `sda_oe` changes 1 clk after the internal `scl_fall`, well inside SCL low.
- `busy` rises on ADDR_ACK entry and falls 1 clk after STOP.

## Configuration
- `I2C_TARGET_READ_EN` defined: R/W=1 with an address match is ACKed and served via RDATA/RDATA_ACK.
- Not defined: RDATA and RDATA_ACK are removed. R/W=1 is NAKed → IGNORE. `rd_data` is unused and `rd_addr` still tracks the sub-address.

## Test plan
- Write 0xE0, 0x0A, 0x55, 0x1F, STOP:
  - 4 ACKs.
  - `wr_en` pulses (0x0A, 0x55), then (0x0B, 0x1F).
  - `busy` falls after STOP.
- Address 0xE2 (7'h71): NAK on the address byte, `sda_oe` stays 0, no `wr_en`, `busy`=0.
- Sub-address 0xFF with data 0x11, 0x22: strobes at 0xFF, then 0x00.
- STOP after 4 bits of a data byte: no `wr_en`, state IDLE, `sda_oe`=0. The next full write works.
- With `I2C_TARGET_READ_EN`: write sub 0x05, repeated START, read 0xE1, controller ACK then NAK, with `rd_data`=0xA0+`rd_addr`:
  - Bytes read are 0xA5 and 0xA6.
  - SDA is released after the NAK.
- `rst_n` pulsed low during the ADDR_ACK slot: `sda_oe` goes 0 within the same cycle, all outputs return to reset values, and the controller sees a NAK.
